// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the run-control front-end: run modes, FSM states and
// the mapping from a requested mode to the state that serves it.
package cpu_run_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'b00,
      MODE_STEP  = 2'b01,
      MODE_HALT  = 2'b10,
      MODE_LIMIT = 2'b11
   } mode_e;

   typedef enum logic [STATE_W-1:0] {
      S_RESET = 3'd0,
      S_RUN   = 3'd1,
      S_STEP  = 3'd2,
      S_HALT  = 3'd3,
      S_LIMIT = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   function automatic state_e mode_state(input mode_e mode);
      state_e st;
      case (mode)
         MODE_RUN:   st = S_RUN;
         MODE_STEP:  st = S_STEP;
         MODE_HALT:  st = S_HALT;
         default:    st = S_LIMIT;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_switch_debounce.sv
// One debounced switch channel: 2-flop synchroniser followed by a stability
// counter that only lets the output follow after DEB_CYCLES steady cycles.
module switch_debounce #(
   parameter int   DEB_CYCLES = 4,
   parameter logic RESET_VAL  = 1'b0
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iEn,
   input  logic iSwitch,
   output logic oSwitch
);

   localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_sync <= {2{RESET_VAL}};
         r_cnt  <= '0;
         r_out  <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[0], iSwitch};
         // On one bit, a change of the synced value while it differs from the
         // output makes it equal again, so this also covers the restart case.
         if (!iEn || (r_sync[1] == r_out)) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_out <= r_sync[1];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign oSwitch = r_out;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control front-end for the processor cores: core reset sequencing,
// divided clock-enable, run/step/halt/limit modes and switch debouncing.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int                  SW_WIDTH   = 8,
   parameter int                  DEB_CYCLES = 4,
   parameter int                  RST_HOLD   = 2,
   parameter int                  DIV_W      = 8,
   parameter int                  CYC_W      = 32,
   parameter logic [SW_WIDTH-1:0] SW_RESET   = '0
) (
   input  logic                iClk,
   input  logic                iRst_n,
   input  logic [SW_WIDTH-1:0] iSwitch,
   input  logic [1:0]          iMode,
   input  logic                iStep,
   input  logic [DIV_W-1:0]    iDiv,
   input  logic [CYC_W-1:0]    iLimit,
   output logic                oCoreRst_n,
   output logic                oCoreEn,
   output logic [SW_WIDTH-1:0] oSwitch,
   output logic [CYC_W-1:0]    oCycles,
   output logic                oDone,
   output logic [STATE_W-1:0]  oState
);

   localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   logic [1:0]        r_rst_sync;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_core_rst_n;
   logic [DIV_W-1:0]  r_div_cnt;
   logic              r_step_q;
   logic              r_step_pend;
   logic              r_core_en;
   logic [CYC_W-1:0]  r_cycles;
   state_e            r_state;

   logic              w_rst_sync;
   logic              w_release;
   logic              w_tick;
   logic              w_step_edge;
   logic              w_en_nxt;
   state_e            w_mode_state;
   state_e            w_state_nxt;

   assign w_rst_sync = r_rst_sync[1];
   assign w_release  = w_rst_sync && !r_core_rst_n && (r_hold_cnt == HOLD_LAST);

   // Core reset asserts with iRst_n and releases RST_HOLD cycles after the
   // synchronised reset goes high.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_rst_sync   <= '0;
         r_hold_cnt   <= '0;
         r_core_rst_n <= 1'b0;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
         if (w_release) begin
            r_core_rst_n <= 1'b1;
         end else if (w_rst_sync && !r_core_rst_n) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
         end
      end
   end

   // Compare is >= so that lowering iDiv below the running count ticks at once.
   assign w_tick = r_core_rst_n && (r_div_cnt >= iDiv);

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_div_cnt <= '0;
      end else if (!r_core_rst_n || w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   assign w_step_edge  = iStep && !r_step_q;
   assign w_mode_state = mode_state(mode_e'(iMode));

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_en_nxt    = 1'b0;
      case (r_state)
         S_RESET: begin
            if (w_release) w_state_nxt = w_mode_state;
         end
         S_RUN: begin
            w_en_nxt    = w_tick;
            w_state_nxt = w_mode_state;
         end
         S_STEP: begin
            w_en_nxt    = w_tick && r_step_pend;
            w_state_nxt = w_mode_state;
         end
         S_HALT: begin
            w_state_nxt = w_mode_state;
         end
         S_LIMIT: begin
            w_en_nxt = w_tick && (r_cycles < iLimit);
            // A limit already passed on entry completes immediately.
            if (r_cycles >= iLimit) w_state_nxt = S_DONE;
            else                    w_state_nxt = w_mode_state;
         end
         S_DONE: begin
            w_state_nxt = S_DONE;
         end
         default: begin
            w_state_nxt = S_RESET;
         end
      endcase
   end

   // oCycles advances on the same edge that raises oCoreEn, so LIMIT sees the
   // count including the pulse in flight and never overshoots.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state     <= S_RESET;
         r_core_en   <= 1'b0;
         r_cycles    <= '0;
         r_step_q    <= 1'b0;
         r_step_pend <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_core_en <= w_en_nxt;
         r_step_q  <= iStep;
         if (w_en_nxt && (r_cycles != '1)) r_cycles <= r_cycles + CYC_W'(1);
         if ((r_state != S_STEP) || (w_state_nxt != S_STEP) || w_en_nxt) begin
            r_step_pend <= 1'b0;
         end else if (w_step_edge) begin
            r_step_pend <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < SW_WIDTH; g++) begin : g_deb
      switch_debounce #(
         .DEB_CYCLES (DEB_CYCLES),
         .RESET_VAL  (SW_RESET[g])
      ) u_deb (
         .iClk    (iClk),
         .iRst_n  (iRst_n),
         .iEn     (w_rst_sync),
         .iSwitch (iSwitch[g]),
         .oSwitch (oSwitch[g])
      );
   end

   assign oCoreRst_n = r_core_rst_n;
   assign oCoreEn    = r_core_en;
   assign oCycles    = r_cycles;
   assign oDone      = (r_state == S_DONE);
   assign oState     = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with default parameters: reset sequencing,
// run/halt/step/limit modes, debounce latency and glitch rejection.
module tb_cpu_run_ctrl;
   import cpu_run_ctrl_pkg::*;

   logic        iClk = 1'b0;
   logic        iRst_n;
   logic [7:0]  iSwitch;
   logic [1:0]  iMode;
   logic        iStep;
   logic [7:0]  iDiv;
   logic [31:0] iLimit;
   logic        oCoreRst_n;
   logic        oCoreEn;
   logic [7:0]  oSwitch;
   logic [31:0] oCycles;
   logic        oDone;
   logic [2:0]  oState;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_run_ctrl dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iSwitch    (iSwitch),
      .iMode      (iMode),
      .iStep      (iStep),
      .iDiv       (iDiv),
      .iLimit     (iLimit),
      .oCoreRst_n (oCoreRst_n),
      .oCoreEn    (oCoreEn),
      .oSwitch    (oSwitch),
      .oCycles    (oCycles),
      .oDone      (oDone),
      .oState     (oState)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle just after the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge iClk);
      #1;
   endtask

   task automatic run_count(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         if (oCoreEn === 1'b1) pulses++;
      end
   endtask

   // Pulse reset, release it, and confirm oCoreRst_n rises exactly after edge 4.
   task automatic reset_dut(input logic [1:0] mode);
      iRst_n = 1'b0;
      iMode  = mode;
      cyc(2);
      iRst_n = 1'b1;
      cyc(3);
      check("rst_hold_low", 32'(oCoreRst_n), 32'd0);
      cyc(1);
      check("rst_released", 32'(oCoreRst_n), 32'd1);
   endtask

   initial begin
      int         p;
      int         q;
      int         tot;
      logic [15:0] pat;
      logic        ok;

      iRst_n  = 1'b0;
      iSwitch = 8'h00;
      iMode   = MODE_RUN;
      iStep   = 1'b0;
      iDiv    = 8'd0;
      iLimit  = 32'd0;

      // 1: reset values, release sequence, free run every cycle
      cyc(2);
      check("reset_core_rst_n", 32'(oCoreRst_n), 32'd0);
      check("reset_core_en",    32'(oCoreEn),    32'd0);
      check("reset_cycles",     oCycles,         32'd0);
      check("reset_done",       32'(oDone),      32'd0);
      check("reset_state",      32'(oState),     32'(S_RESET));
      check("reset_switch",     32'(oSwitch),    32'h00);
      reset_dut(MODE_RUN);
      check("run_state",        32'(oState),     32'(S_RUN));
      check("run_first_en_low", 32'(oCoreEn),    32'd0);
      run_count(10, p);
      check("run_div0_pulses",  32'(p),          32'd10);
      check("run_div0_cycles",  oCycles,         32'd10);

      // 2: divide by 4, halt mid-count, resume
      iDiv = 8'd3;
      pat  = '0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         pat[i] = oCoreEn;
      end
      check("div4_pattern", 32'(pat), 32'h8888);
      check("div4_cycles",  oCycles,  32'd14);
      cyc(2);
      iMode = MODE_HALT;
      run_count(12, p);
      check("halt_pulses", 32'(p),      32'd0);
      check("halt_cycles", oCycles,     32'd14);
      check("halt_state",  32'(oState), 32'(S_HALT));
      iMode = MODE_RUN;
      run_count(16, p);
      check("resume_pulses", 32'(p),  32'd4);
      check("resume_cycles", oCycles, 32'd18);

      // 3: single-step
      iDiv = 8'd0;
      reset_dut(MODE_STEP);
      check("step_state", 32'(oState), 32'(S_STEP));
      run_count(5, p);
      check("step_idle_pulses", 32'(p), 32'd0);
      tot = 0;
      for (int k = 0; k < 3; k++) begin
         iStep = 1'b1;
         run_count(1, p);
         iStep = 1'b0;
         run_count(3, q);
         tot += p + q;
      end
      check("step_three_pulses", 32'(tot), 32'd3);
      check("step_three_cycles", oCycles,  32'd3);
      iStep = 1'b1;
      run_count(5, p);
      iStep = 1'b0;
      run_count(4, q);
      check("step_held_pulses", 32'(p + q), 32'd1);
      check("step_held_cycles", oCycles,    32'd4);
      iDiv  = 8'd7;
      iStep = 1'b1;
      run_count(1, tot);
      iStep = 1'b0;
      run_count(1, p);
      tot += p;
      iStep = 1'b1;
      run_count(1, p);
      tot += p;
      iStep = 1'b0;
      run_count(16, p);
      tot += p;
      check("step_double_edge_pulses", 32'(tot), 32'd1);
      check("step_double_edge_cycles", oCycles,  32'd5);

      // 4: run to limit, then limit of zero
      iDiv   = 8'd1;
      iLimit = 32'd5;
      reset_dut(MODE_LIMIT);
      run_count(6, p);
      check("limit_part_pulses", 32'(p),     32'd3);
      check("limit_part_done",   32'(oDone), 32'd0);
      run_count(14, p);
      check("limit_rest_pulses", 32'(p),      32'd2);
      check("limit_done",        32'(oDone),  32'd1);
      check("limit_state",       32'(oState), 32'(S_DONE));
      check("limit_cycles",      oCycles,     32'd5);
      iMode = MODE_RUN;
      run_count(10, p);
      check("done_ignores_mode_pulses", 32'(p),      32'd0);
      check("done_ignores_mode_state",  32'(oState), 32'(S_DONE));
      iDiv   = 8'd0;
      iLimit = 32'd0;
      reset_dut(MODE_LIMIT);
      run_count(10, p);
      check("limit0_pulses", 32'(p),     32'd0);
      check("limit0_done",   32'(oDone), 32'd1);
      check("limit0_cycles", oCycles,    32'd0);

      // 5: debounce latency and glitch rejection
      iSwitch = 8'hfc;
      cyc(5);
      check("deb_not_yet", 32'(oSwitch), 32'h00);
      cyc(1);
      check("deb_latency", 32'(oSwitch), 32'hfc);
      ok      = 1'b1;
      iSwitch = 8'h00;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         if (oSwitch !== 8'hfc) ok = 1'b0;
      end
      iSwitch = 8'hfc;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (oSwitch !== 8'hfc) ok = 1'b0;
      end
      check("deb_glitch_rejected", 32'(ok), 32'd1);
      iSwitch = 8'h5a;
      cyc(5);
      check("deb_mixed_not_yet", 32'(oSwitch), 32'hfc);
      cyc(1);
      check("deb_mixed_latency", 32'(oSwitch), 32'h5a);

      // 6: asynchronous reset in the middle of a LIMIT run
      iLimit = 32'd100;
      reset_dut(MODE_LIMIT);
      run_count(10, p);
      check("midrun_pulses", 32'(p),       32'd10);
      check("midrun_switch", 32'(oSwitch), 32'h5a);
      #2;
      iRst_n = 1'b0;
      #1;
      check("async_core_rst_n", 32'(oCoreRst_n), 32'd0);
      check("async_core_en",    32'(oCoreEn),    32'd0);
      check("async_cycles",     oCycles,         32'd0);
      check("async_done",       32'(oDone),      32'd0);
      check("async_state",      32'(oState),     32'(S_RESET));
      check("async_switch",     32'(oSwitch),    32'h00);
      cyc(1);
      iRst_n = 1'b1;
      cyc(3);
      check("rerelease_hold_low", 32'(oCoreRst_n), 32'd0);
      cyc(1);
      check("rerelease_rst_n",  32'(oCoreRst_n), 32'd1);
      check("rerelease_cycles", oCycles,         32'd0);
      check("rerelease_done",   32'(oDone),      32'd0);
      check("rerelease_state",  32'(oState),     32'(S_LIMIT));
      run_count(3, p);
      check("rerelease_pulses", 32'(p),  32'd3);
      check("rerelease_count",  oCycles, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run-control front-end for the processor cores: single-cycle now, later multi-cycle and pipelined.
- Sequences core reset release and generates a divided core clock-enable.
- Supports free-run, single-step, halt and run-to-cycle-limit modes.
- Debounces a parametrised bank of board switches feeding the core's switch input.
- Sits between board pins and the core top; the same block drives the core in simulation and on FPGA.

Parameters:
- SW_WIDTH, 8: number of switch channels.
- DEB_CYCLES, 4: consecutive stable cycles before a switch output changes (>=1).
- RST_HOLD, 2: cycles oCoreRst_n stays low after synchronised reset release (>=1).
- DIV_W, 8: width of the clock-enable divider.
- CYC_W, 32: width of the enable counter and cycle limit.
- SW_RESET, 0: reset value of oSwitch.

Ports:
- iClk, input, 1: system clock, rising edge.
- iRst_n, input, 1: asynchronous active-low reset.
- iSwitch, input, SW_WIDTH: raw, asynchronous switch inputs.
- iMode, input, 2: run mode. 00 RUN, 01 STEP, 10 HALT, 11 LIMIT.
- iStep, input, 1: synchronous step request. A rising edge is detected internally.
- iDiv, input, DIV_W: enable period minus 1. 0 means an enable every cycle.
- iLimit, input, CYC_W: enable count at which LIMIT mode stops.
- oCoreRst_n, output, 1: core reset. Active low, asserts asynchronously, deasserts synchronously.
- oCoreEn, output, 1: core clock-enable, one-cycle pulses.
- oSwitch, output, SW_WIDTH: debounced switches.
- oCycles, output, CYC_W: number of oCoreEn pulses issued since reset. Saturates at all-ones.
- oDone, output, 1: sticky; LIMIT reached.
- oState, output, 3: current FSM state encoding.

Behaviour:
Reset
- While iRst_n=0, all flops clear asynchronously:
  - oCoreRst_n=0, oCoreEn=0, oCycles=0, oDone=0, oState=S_RESET, oSwitch=SW_RESET.
  - The divider counter, hold counter and step-pending flag are cleared.
- iRst_n is released through a 2-flop synchroniser.
- The hold counter counts from the first cycle the synchronised reset is high.
- oCoreRst_n rises RST_HOLD cycles later. With edge 1 as the first rising edge having iRst_n=1, oCoreRst_n is 1 after edge 2+RST_HOLD.
- A new iRst_n assertion mid-run returns everything to reset values immediately.

Divider
- Active only while oCoreRst_n=1.
- tick=1 when divider count >= iDiv; the count then goes to 0, otherwise it increments.
- Because the compare is >=, lowering iDiv mid-count gives a tick on the next cycle.

FSM states
- S_RESET: exits to the iMode-selected state on the cycle oCoreRst_n rises.
- S_RUN: oCoreEn=tick.
- S_STEP:
  - An iStep rising edge sets step_pend.
  - oCoreEn=tick&step_pend; step_pend clears on that cycle.
  - Extra iStep edges while pending are ignored (exactly one enable per pending step).
- S_HALT: oCoreEn=0; the divider keeps running.
- S_LIMIT:
  - oCoreEn=tick while oCycles<iLimit.
  - The cycle oCycles==iLimit is observed, go to S_DONE.
  - iLimit=0 goes to S_DONE with no enable.
- S_DONE: oCoreEn=0 and oDone=1. Exits only on reset; iMode is ignored.

Mode changes
- iMode is sampled every cycle. A change moves the FSM next cycle (from RUN/STEP/HALT/LIMIT only).
- Leaving S_STEP clears step_pend.
- Entering S_LIMIT does not clear oCycles; the limit is absolute.

oCoreEn and oCycles
- oCoreEn is registered: the pulse appears the cycle after the tick condition is evaluated.
- oCycles increments with each oCoreEn pulse.

Debounce, per channel
- 2-flop synchroniser feeding a stability counter.
- The counter resets whenever the synced value equals oSwitch[i] or changes.
- oSwitch[i] updates once the synced value has differed from it for DEB_CYCLES consecutive cycles.
- Glitches shorter than DEB_CYCLES are rejected. Latency is 2+DEB_CYCLES cycles.
- Debounce runs from synchronised reset release, independent of the FSM.

Decomposition:
- Package cpu_run_ctrl_pkg holds:
  - the mode encodings (MODE_RUN, MODE_STEP, MODE_HALT, MODE_LIMIT);
  - the state encodings (S_RESET, S_RUN, S_STEP, S_HALT, S_LIMIT, S_DONE);
  - the oState width constant.
- Sub-module switch_debounce: one channel, parameter DEB_CYCLES, generated SW_WIDTH times.
- Reset synchroniser, divider and FSM stay in cpu_run_ctrl.

Test Plan:
1. Reset release, RST_HOLD=2, iMode=RUN, iDiv=0.
   - oCoreRst_n rises after edge 4.
   - oCoreEn is high every cycle thereafter; oCycles=10 after 10 pulses.
2. iDiv=3, RUN.
   - oCoreEn pulses exactly every 4 cycles.
   - Switching to HALT mid-count gives no further pulses and oCycles frozen.
   - Returning to RUN resumes pulses.
3. STEP mode, iDiv=0.
   - Three iStep pulses give exactly 3 oCoreEn pulses, oCycles=3.
   - iStep held high for 5 cycles gives 1 pulse.
4. LIMIT mode, iLimit=5, iDiv=1.
   - 5 pulses occur, then oDone=1 and the FSM is in S_DONE.
   - Changing iMode to RUN gives no pulses.
   - A separate run with iLimit=0 sets oDone with 0 pulses.
5. Debounce, DEB_CYCLES=4, SW_RESET=0.
   - iSwitch=8'hfc held: oSwitch=8'hfc after 6 cycles.
   - A 3-cycle glitch to 8'h00 leaves oSwitch at 8'hfc.
6. iRst_n asserted mid-LIMIT run.
   - All outputs return to reset values asynchronously.
   - After release, oCycles=0, oDone=0 and the reset sequence repeats.
